// File: rtl/task_in_stream.sv
// task_in_stream: AXI-Stream frame stager with an internal FIFO and a serialiser whose beat width is chosen at runtime.
// Optional build macro TASK_IN_STREAM_MSB_FIRST_EN: emit the most-significant lane group first.
module task_in_stream #(
  parameter int IN_WIDTH   = 32,
  parameter int FIFO_DEPTH = 256,
  parameter int LEN_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_out_bytes,
  input  logic [7:0]            i_last_bytes,
  input  logic [IN_WIDTH-1:0]   s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  o_tready,
  output logic [IN_WIDTH-1:0]   o_data,
  output logic [IN_WIDTH/8-1:0] o_keep,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_cfg_err,
  output logic [LEN_W-1:0]      o_word_count
);
  localparam int NB = IN_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [3:0]          ob_log_q, start_log_s;
  logic [7:0]          last_bytes_q;
  logic                first_pend_q, cfg_err_q;
  logic [LEN_W-1:0]    word_cnt_q;
  logic [IN_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         cnt_q;
  logic [7:0]          beat_q;
  logic [IN_WIDTH-1:0] data_q;
  logic [NB-1:0]       keep_q;
  logic                valid_q, first_q, last_q;

  logic                legal_s, start_ok_s, push_s, pop_s, load_s, adv_s, full_s;
  logic [IN_WIDTH:0]   head_s;
  logic [8:0]          ob_s, groups_s, valid_bytes_s, beats_total_s, offset_s;
  logic                final_beat_s;
  logic [IN_WIDTH-1:0] shifted_s, beat_data_s;
  logic [NB-1:0]       beat_keep_s;

  // Configuration decode: beat width must be a power of two no wider than the bus.
  always_comb begin
    start_log_s = 4'd0;
    for (int b = 0; b < 8; b++) begin
      start_log_s = (i_out_bytes == (8'd1 << b)) ? 4'(b) : start_log_s;
    end
    legal_s = (i_out_bytes != 8'd0) && ((i_out_bytes & (i_out_bytes - 8'd1)) == 8'd0) &&
              ({1'b0, i_out_bytes} <= 9'(NB)) && ({1'b0, i_last_bytes} <= 9'(NB));
    start_ok_s = i_start && (state_q == IDLE) && legal_s;
  end

  assign full_s   = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign o_tready = (state_q == RUN) && !full_s;
  assign push_s   = s_tvalid && o_tready;
  assign adv_s    = !valid_q || i_ready;
  assign load_s   = adv_s && (cnt_q != (AW+1)'(0));
  assign pop_s    = load_s && final_beat_s;

  // Beat extraction straight from the FIFO head word.
  always_comb begin
    head_s        = mem_q[rd_ptr_q];
    ob_s          = 9'd1 << ob_log_q;
    groups_s      = 9'(NB) >> ob_log_q;
    valid_bytes_s = head_s[IN_WIDTH] ? {1'b0, last_bytes_q} : 9'(NB);
    beats_total_s = head_s[IN_WIDTH] ? ((valid_bytes_s + ob_s - 9'd1) >> ob_log_q) : groups_s;
    final_beat_s  = ({1'b0, beat_q} == (beats_total_s - 9'd1));
`ifdef TASK_IN_STREAM_MSB_FIRST_EN
    offset_s      = (groups_s - 9'd1 - {1'b0, beat_q}) << ob_log_q;
`else
    offset_s      = {1'b0, beat_q} << ob_log_q;
`endif
    shifted_s     = head_s[IN_WIDTH-1:0] >> {offset_s, 3'b000};
    beat_data_s   = '0;
    beat_keep_s   = '0;
    for (int j = 0; j < NB; j++) begin
`ifdef TASK_IN_STREAM_MSB_FIRST_EN
      beat_keep_s[j] = (9'(j) < ob_s) && ((offset_s + 9'(j)) >= (9'(NB) - valid_bytes_s));
`else
      beat_keep_s[j] = (9'(j) < ob_s) && ((offset_s + 9'(j)) < valid_bytes_s);
`endif
      beat_data_s[8*j +: 8] = beat_keep_s[j] ? shifted_s[8*j +: 8] : 8'd0;
    end
  end

  // Frame-level next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_ok_s ? RUN : IDLE;
      RUN:     state_d = (push_s && s_tlast) ? DRAIN : RUN;
      DRAIN:   state_d = (valid_q && last_q && i_ready) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // State, latched configuration and word counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ob_log_q     <= 4'd0;
      last_bytes_q <= 8'd0;
      first_pend_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= i_start && (state_q == IDLE) && !legal_s;
      if (start_ok_s) begin
        ob_log_q     <= start_log_s;
        last_bytes_q <= (i_last_bytes == 8'd0) ? 8'(NB) : i_last_bytes;
        first_pend_q <= 1'b1;
        word_cnt_q   <= '0;
      end else begin
        first_pend_q <= load_s ? 1'b0 : first_pend_q;
        if (push_s && (word_cnt_q != {LEN_W{1'b1}})) word_cnt_q <= word_cnt_q + LEN_W'(1);
        else word_cnt_q <= word_cnt_q;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (push_s) mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
  end

  // FIFO pointers, occupancy and beat index within the head word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= 8'd0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (pop_s)       beat_q <= 8'd0;
      else if (load_s) beat_q <= beat_q + 8'd1;
      else             beat_q <= beat_q;
    end
  end

  // Output beat register: only advances when empty or accepted downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_s) begin
      data_q  <= beat_data_s;
      keep_q  <= beat_keep_s;
      valid_q <= 1'b1;
      first_q <= first_pend_q;
      last_q  <= final_beat_s && head_s[IN_WIDTH];
    end else if (adv_s) begin
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign o_data       = data_q;
  assign o_keep       = keep_q;
  assign o_valid      = valid_q;
  assign o_first      = first_q;
  assign o_last       = last_q;
  assign o_busy       = (state_q != IDLE);
  assign o_cfg_err    = cfg_err_q;
  assign o_word_count = word_cnt_q;
endmodule

// File: tb/tb_task_in_stream.sv
// Directed bench for task_in_stream with a beat scoreboard fed by the stimulus sequence.
module tb_task_in_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_out_bytes = 8'd4;
  logic [7:0]  i_last_bytes = 8'd4;
  logic [31:0] s_tdata = 32'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        i_ready = 1'b1;
  logic        o_tready, o_valid, o_first, o_last, o_busy, o_cfg_err;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic [15:0] o_word_count;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [37:0] sb[$];
  logic        tog_en = 1'b0;
  logic        rdy_level = 1'b1;
  logic        saw_full = 1'b0;
  logic        hold_pend = 1'b0;
  logic [37:0] hold_val = '0;

  task_in_stream #(.IN_WIDTH(32), .FIFO_DEPTH(4), .LEN_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_out_bytes(i_out_bytes),
    .i_last_bytes(i_last_bytes), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .o_tready(o_tready), .o_data(o_data), .o_keep(o_keep), .o_valid(o_valid), .i_ready(i_ready),
    .o_first(o_first), .o_last(o_last), .o_busy(o_busy), .o_cfg_err(o_cfg_err),
    .o_word_count(o_word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic f, input logic l);
    sb.push_back({f, l, k, d});
  endtask

  task automatic start_frame(input logic [7:0] ob, input logic [7:0] lb);
    i_out_bytes = ob; i_last_bytes = lb; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = l;
    @(negedge clk);
    while (!o_tready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("tready_timeout", 64'(o_tready), 64'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_busy || sb.size() != 0) && n < 400) begin @(posedge clk); #1; n++; end
    chk(tag, 64'(o_busy || (sb.size() != 0)), 64'd0);
  endtask

  // Downstream ready driver: steady level or toggling every cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      i_ready = tog_en ? ~i_ready : rdy_level;
    end
  end

  // Output monitor: scoreboard pop on handshake, hold check while stalled.
  initial begin : monitor
    logic [37:0] obs, e;
    forever begin
      @(negedge clk);
      obs = {o_first, o_last, o_keep, o_data};
      if (rst) hold_pend = 1'b0;
      else begin
        if (hold_pend) chk("axi_hold", 64'(obs), 64'(hold_val));
        hold_pend = 1'b0;
        if (s_tvalid && !o_tready && o_busy) saw_full = 1'b1;
        if (o_valid && i_ready) begin
          if (sb.size() == 0) chk("unexpected_beat", 64'(obs), 64'd0);
          else begin
            e = sb.pop_front();
            chk("beat", 64'(obs), 64'(e));
          end
        end else if (o_valid) begin
          hold_pend = 1'b1;
          hold_val  = obs;
        end
      end
    end
  end

  task automatic test1();
    start_frame(8'd4, 8'd4);
    chk("t1_busy", 64'(o_busy), 64'd1);
    i_out_bytes = 8'd1; i_last_bytes = 8'd2;
    exp_beat(32'hA1A2A3A4, 4'hF, 1'b1, 1'b0);
    exp_beat(32'hB1B2B3B4, 4'hF, 1'b0, 1'b0);
    exp_beat(32'hC1C2C3C4, 4'hF, 1'b0, 1'b1);
    send_word(32'hA1A2A3A4, 1'b0);
    send_word(32'hB1B2B3B4, 1'b0);
    send_word(32'hC1C2C3C4, 1'b1);
    wait_idle("t1_idle");
    chk("t1_count", 64'(o_word_count), 64'd3);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({o_valid, o_first, o_last, o_busy, o_cfg_err, o_tready, o_keep}), 64'd0);
    chk("rst_data", 64'({o_word_count, o_data}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    test1();

    start_frame(8'd1, 8'd3);
`ifdef TASK_IN_STREAM_MSB_FIRST_EN
    exp_beat(32'h000000DD, 4'h1, 1'b1, 1'b0);
    exp_beat(32'h000000CC, 4'h1, 1'b0, 1'b0);
    exp_beat(32'h000000BB, 4'h1, 1'b0, 1'b1);
`else
    exp_beat(32'h000000AA, 4'h1, 1'b1, 1'b0);
    exp_beat(32'h000000BB, 4'h1, 1'b0, 1'b0);
    exp_beat(32'h000000CC, 4'h1, 1'b0, 1'b1);
`endif
    send_word(32'hDDCCBBAA, 1'b1);
    wait_idle("t2_idle");

    start_frame(8'd2, 8'd1);
`ifdef TASK_IN_STREAM_MSB_FIRST_EN
    exp_beat(32'h00004433, 4'h3, 1'b1, 1'b0);
    exp_beat(32'h00002211, 4'h3, 1'b0, 1'b0);
    exp_beat(32'h00008800, 4'h2, 1'b0, 1'b1);
`else
    exp_beat(32'h00002211, 4'h3, 1'b1, 1'b0);
    exp_beat(32'h00004433, 4'h3, 1'b0, 1'b0);
    exp_beat(32'h00000055, 4'h1, 1'b0, 1'b1);
`endif
    send_word(32'h44332211, 1'b0);
    start_frame(8'd4, 8'd4);
    send_word(32'h88776655, 1'b1);
    wait_idle("t3_idle");
    chk("t3_count", 64'(o_word_count), 64'd2);

    saw_full = 1'b0;
    tog_en = 1'b1;
    start_frame(8'd4, 8'd0);
    for (int i = 0; i < 16; i++) exp_beat(32'h10000000 + 32'(i) * 32'h01010101, 4'hF, i == 0, i == 15);
    for (int i = 0; i < 16; i++) send_word(32'h10000000 + 32'(i) * 32'h01010101, i == 15);
    wait_idle("t4_idle");
    tog_en = 1'b0;
    chk("t4_saw_full", 64'(saw_full), 64'd1);
    chk("t4_count", 64'(o_word_count), 64'd16);

    start_frame(8'd3, 8'd4);
    chk("t5_cfg_err", 64'({o_cfg_err, o_busy, o_tready}), 64'b100);
    @(posedge clk); #1;
    chk("t5_cfg_err_pulse", 64'({o_cfg_err, o_busy, o_tready}), 64'b000);
    start_frame(8'd4, 8'd5);
    chk("t5_last_err", 64'({o_cfg_err, o_busy}), 64'b10);

    rdy_level = 1'b0;
    @(posedge clk); #1;
    start_frame(8'd4, 8'd4);
    send_word(32'h01020304, 1'b0);
    send_word(32'h05060708, 1'b0);
    send_word(32'h090A0B0C, 1'b1);
    chk("t6_drain", 64'({o_busy, o_tready, o_valid}), 64'b101);
    rst = 1'b1;
    #1;
    chk("t6_rst_outputs", 64'({o_valid, o_first, o_last, o_busy, o_cfg_err, o_tready, o_keep}), 64'd0);
    chk("t6_rst_data", 64'({o_word_count, o_data}), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_level = 1'b1;
    @(posedge clk); #1;
    test1();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
